// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: holds the architectural PC, issues one doubleword
// fetch per instruction on a variable-latency memory port, extracts the
// 32-bit word and presents it to execute with a valid/ready handshake.
// The next PC comes from execute (dnpc) at the moment the instruction is taken.
module ysyx_22050612_ifu #(
   parameter logic [63:0] RESET_PC = 64'h8000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [63:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [63:0] mem_resp_data,
   input  logic        mem_resp_err,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [63:0] inst_pc,
   output logic [1:0]  inst_fault,
   input  logic [63:0] dnpc
);

   // Timer wide enough to hold TIMEOUT-1 with headroom for the increment.
   localparam int unsigned    TW         = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0]  TIMER_ONE  = TW'(1);

   localparam logic [1:0] FAULT_OK    = 2'd0;
   localparam logic [1:0] FAULT_BUS   = 2'd1;
   localparam logic [1:0] FAULT_TMO   = 2'd2;
   localparam logic [1:0] FAULT_ALIGN = 2'd3;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t         state_r;
   logic [63:0]    pc_r;
   logic [TW-1:0]  timer_r;
   logic [31:0]    inst_r;
   logic [1:0]     fault_r;
   logic           req_valid_r;
   logic           inst_valid_r;

   // The request flag and the instruction-valid flag are kept as registers that
   // are updated together with the state, so they always equal
   // (state==REQ && pc aligned) and (state==HOLD) without combinational decode.
   assign mem_req_valid = req_valid_r;
   assign inst_valid    = inst_valid_r;
   assign mem_req_addr  = {pc_r[63:3], 3'b000};
   assign inst_pc       = pc_r;
   assign inst          = inst_r;
   assign inst_fault    = fault_r;

   // Fetch FSM: PC, timeout timer, captured instruction and handshake flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= BOOT;
         pc_r         <= RESET_PC;
         timer_r      <= '0;
         inst_r       <= 32'h0000_0000;
         fault_r      <= FAULT_OK;
         req_valid_r  <= 1'b0;
         inst_valid_r <= 1'b0;
      end else begin
         case (state_r)
            BOOT: begin
               // A misaligned reset vector is reported at the first REQ like any other.
               state_r     <= REQ;
               req_valid_r <= (pc_r[1:0] == 2'b00);
            end
            REQ: begin
               if (pc_r[1:0] != 2'b00) begin
                  // No bus access for a misaligned PC; present a fault instead.
                  state_r      <= HOLD;
                  inst_r       <= 32'h0000_0000;
                  fault_r      <= FAULT_ALIGN;
                  inst_valid_r <= 1'b1;
               end else if (mem_req_ready) begin
                  state_r     <= WAIT;
                  timer_r     <= '0;
                  req_valid_r <= 1'b0;
               end
            end
            WAIT: begin
               timer_r <= timer_r + TIMER_ONE;
               if (mem_resp_valid) begin
                  // A response in the timeout cycle still wins.
                  state_r      <= HOLD;
                  inst_r       <= pc_r[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];
                  fault_r      <= mem_resp_err ? FAULT_BUS : FAULT_OK;
                  inst_valid_r <= 1'b1;
               end else if (timer_r == TIMER_LAST) begin
                  state_r      <= HOLD;
                  inst_r       <= 32'h0000_0000;
                  fault_r      <= FAULT_TMO;
                  inst_valid_r <= 1'b1;
               end
            end
            HOLD: begin
               // Outputs stay frozen until execute takes the instruction.
               if (inst_ready) begin
                  state_r      <= REQ;
                  pc_r         <= dnpc;
                  inst_valid_r <= 1'b0;
                  req_valid_r  <= (dnpc[1:0] == 2'b00);
               end
            end
            default: begin
               state_r      <= BOOT;
               req_valid_r  <= 1'b0;
               inst_valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Directed bench for ysyx_22050612_ifu. The driver plays memory and execute,
// and keeps an expected-output record (pc, request pending, instruction
// presented, word, fault) derived from the fetch rules and their latencies.
// A negedge process compares the DUT against that record every cycle.
module tb_ysyx_22050612_ifu;

   localparam logic [63:0] RESET_PC = 64'h8000_0000;
   localparam int          TIMEOUT  = 16;

   logic        clk;
   logic        rst;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [63:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_data;
   logic        mem_resp_err;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic [1:0]  inst_fault;
   logic [63:0] dnpc;

   ysyx_22050612_ifu #(
      .RESET_PC (RESET_PC),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .mem_resp_err   (mem_resp_err),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_fault     (inst_fault),
      .dnpc           (dnpc)
   );

   int n_vec = 0;
   int n_err = 0;

   // expected-output record
   logic        chk_en;
   logic [63:0] exp_pc;
   logic        exp_req;
   logic        exp_valid;
   logic [31:0] exp_inst;
   logic [1:0]  exp_fault;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // per-cycle compare against the expected record
   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_valid", {63'd0, mem_req_valid}, {63'd0, exp_req});
         chk("inst_valid", {63'd0, inst_valid}, {63'd0, exp_valid});
         chk("inst_pc", inst_pc, exp_pc);
         chk("req_addr", mem_req_addr, {exp_pc[63:3], 3'b000});
         if (exp_valid) begin
            chk("inst", {32'd0, inst}, {32'd0, exp_inst});
            chk("inst_fault", {62'd0, inst_fault}, {62'd0, exp_fault});
         end
      end
   end

   // hold the request for ready_delay cycles, then accept it
   task automatic issue(input int ready_delay);
      repeat (ready_delay) tick();
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      exp_req = 1'b0;
   endtask

   // respond after 'delay' idle WAIT cycles
   task automatic respond(input int delay, input logic [63:0] data, input logic err);
      repeat (delay) tick();
      mem_resp_valid = 1'b1;
      mem_resp_data  = data;
      mem_resp_err   = err;
      tick();
      mem_resp_valid = 1'b0;
      mem_resp_data  = 64'hA5A5_A5A5_5A5A_5A5A;
      mem_resp_err   = 1'b0;
      exp_valid = 1'b1;
      exp_inst  = exp_pc[2] ? data[63:32] : data[31:0];
      exp_fault = err ? 2'd1 : 2'd0;
   endtask

   // keep execute stalled for hold cycles, then take the instruction
   task automatic accept(input int hold, input logic [63:0] next_pc);
      repeat (hold) tick();
      inst_ready = 1'b1;
      dnpc       = next_pc;
      tick();
      inst_ready = 1'b0;
      dnpc       = 64'hFFFF_FFFF_FFFF_FFF0;
      exp_valid  = 1'b0;
      exp_pc     = next_pc;
      exp_req    = (next_pc[1:0] == 2'b00);
   endtask

   initial begin
      rst            = 1'b1;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 64'd0;
      mem_resp_err   = 1'b0;
      inst_ready     = 1'b0;
      dnpc           = 64'd0;
      chk_en         = 1'b0;
      exp_pc         = RESET_PC;
      exp_req        = 1'b0;
      exp_valid      = 1'b0;
      exp_inst       = 32'd0;
      exp_fault      = 2'd0;

      // reset state
      tick();
      tick();
      chk("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
      chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
      chk("rst_inst", {32'd0, inst}, 64'd0);
      chk("rst_fault", {62'd0, inst_fault}, 64'd0);
      chk("rst_pc", inst_pc, 64'h8000_0000);
      rst    = 1'b0;
      chk_en = 1'b1;
      tick();
      exp_req = 1'b1;

      // reset then fetch, lower and upper word of the same doubleword
      issue(0);
      respond(0, 64'h0000_0013_0010_0073, 1'b0);
      chk("lit_inst0", {32'd0, inst}, 64'h0000_0000_0010_0073);
      chk("lit_pc0", inst_pc, 64'h8000_0000);
      accept(0, 64'h8000_0004);
      chk("lit_addr1", mem_req_addr, 64'h8000_0000);
      issue(0);
      respond(0, 64'h0000_0013_0010_0073, 1'b0);
      chk("lit_inst1", {32'd0, inst}, 64'h0000_0000_0000_0013);
      accept(0, 64'h8000_0008);

      // backpressure on both sides
      issue(3);
      respond(2, 64'h00A0_0513_00B0_0593, 1'b0);
      accept(5, 64'h8000_000C);

      // timeout, then a stray response in HOLD
      issue(0);
      repeat (TIMEOUT - 1) tick();
      tick();
      exp_valid = 1'b1;
      exp_inst  = 32'd0;
      exp_fault = 2'd2;
      chk("lit_tmo_fault", {62'd0, inst_fault}, 64'd2);
      tick();
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'hDEAD_BEEF_CAFE_F00D;
      mem_resp_err   = 1'b1;
      tick();
      mem_resp_valid = 1'b0;
      mem_resp_err   = 1'b0;
      tick();
      accept(0, 64'h8000_0010);

      // response in the last WAIT cycle beats the timeout
      issue(0);
      respond(TIMEOUT - 1, 64'h1111_1111_2222_2222, 1'b0);
      chk("lit_late_inst", {32'd0, inst}, 64'h0000_0000_2222_2222);
      chk("lit_late_fault", {62'd0, inst_fault}, 64'd0);
      accept(1, 64'h8000_0014);

      // bus error, upper word
      issue(0);
      respond(0, 64'h3333_3333_4444_4444, 1'b1);
      chk("lit_err_inst", {32'd0, inst}, 64'h0000_0000_3333_3333);
      chk("lit_err_fault", {62'd0, inst_fault}, 64'd1);
      accept(0, 64'h8000_0002);

      // misaligned dnpc
      tick();
      exp_valid = 1'b1;
      exp_inst  = 32'd0;
      exp_fault = 2'd3;
      chk("lit_mis_pc", inst_pc, 64'h8000_0002);
      chk("lit_mis_fault", {62'd0, inst_fault}, 64'd3);
      accept(2, 64'h8000_0018);

      // ordinary fetch leaves a nonzero word behind
      issue(0);
      respond(0, 64'h5555_5555_6666_6666, 1'b0);
      accept(0, 64'h8000_0020);

      // reset in the middle of WAIT
      issue(0);
      tick();
      #2;
      chk_en = 1'b0;
      rst    = 1'b1;
      #1;
      chk("mid_rst_inst_valid", {63'd0, inst_valid}, 64'd0);
      chk("mid_rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
      chk("mid_rst_inst", {32'd0, inst}, 64'd0);
      chk("mid_rst_fault", {62'd0, inst_fault}, 64'd0);
      chk("mid_rst_pc", inst_pc, 64'h8000_0000);
      tick();
      rst            = 1'b0;
      exp_pc         = RESET_PC;
      exp_req        = 1'b0;
      exp_valid      = 1'b0;
      chk_en         = 1'b1;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'h7777_7777_8888_8888;
      tick();
      exp_req = 1'b1;
      tick();
      mem_resp_valid = 1'b0;
      chk("lit_rst_addr", mem_req_addr, 64'h8000_0000);
      issue(0);
      respond(0, 64'h0000_0013_0010_0073, 1'b0);
      chk("lit_rst_inst", {32'd0, inst}, 64'h0000_0000_0010_0073);
      accept(0, 64'h8000_0004);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
